// File: rtl/dbg_stats_reader_pkg.sv
// Shared definitions for the debug-statistics reader: command opcodes, field
// positions, the invalid-response marker and the sequencer state encoding.
package dbg_stats_reader_pkg;

    localparam logic [15:0] DBG_CMD_READ  = 16'd0;
    localparam logic [15:0] DBG_CMD_RESET = 16'd1;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 15;
    localparam int INDEX_LSB  = 16;
    localparam int INDEX_MSB  = 31;

    localparam logic [63:0] DBG_INVALID_MARKER = 64'hDEADBEEFBAADF00D;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_READ  = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_OUT_LO    = 3'd3,
        ST_OUT_HI    = 3'd4,
        ST_CMD_RESET = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    function automatic logic [31:0] make_cmd(input logic [15:0] index, input logic [15:0] opcode);
        logic [31:0] cmd;
        cmd = '0;
        cmd[INDEX_MSB:INDEX_LSB]   = index;
        cmd[OPCODE_MSB:OPCODE_LSB] = opcode;
        return cmd;
    endfunction

endpackage

// File: rtl/dbg_stats_reader.sv
// Debug-statistics link initiator: sweeps READ commands, streams each 64-bit
// response as two 32-bit words, optionally finishes with a RESET command.
// Optional response timeout is enabled by defining DBG_READER_TIMEOUT_EN.
module dbg_stats_reader
    import dbg_stats_reader_pkg::*;
#(
    parameter int N_COUNTERS     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk150,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_clear,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_cmd_data,
    output logic        o_cmd_have,
    input  logic        i_cmd_want,
    input  logic [63:0] i_resp_data,
    input  logic        i_resp_have,
    output logic        o_resp_want,
    output logic [31:0] o_out_data,
    output logic        o_out_have,
    input  logic        i_out_want,
    output logic        o_err
);

    if (N_COUNTERS < 1 || N_COUNTERS > 65535 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("dbg_stats_reader: parameter out of range");
    end

    state_t      state;
    state_t      state_next;
    logic [15:0] index;
    logic        clear_pending;
    logic [63:0] capture;
    logic        cmd_xfer;
    logic        resp_xfer;
    logic        out_xfer;
    logic        last_index;
    logic        timeout_hit;

    assign cmd_xfer   = o_cmd_have & i_cmd_want;
    assign resp_xfer  = o_resp_want & i_resp_have;
    assign out_xfer   = o_out_have & i_out_want;
    assign last_index = (index == 16'(N_COUNTERS - 1));

`ifdef DBG_READER_TIMEOUT_EN
    logic [31:0] wait_count;
    logic        err;

    // Counter is held at zero outside WAIT_RESP, so every wait starts fresh.
    always_ff @(posedge i_clk150 or posedge i_reset) begin
        if (i_reset) begin
            wait_count <= '0;
            err        <= 1'b0;
        end else begin
            if (state == ST_WAIT_RESP) begin
                wait_count <= wait_count + 32'd1;
            end else begin
                wait_count <= '0;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state == ST_WAIT_RESP) && !resp_xfer &&
                         (wait_count == 32'(TIMEOUT_CYCLES - 1));
    assign o_err       = err;
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_ff @(posedge i_clk150 or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_CMD_READ;
                end else if (i_clear) begin
                    state_next = ST_CMD_RESET;
                end
            end
            ST_CMD_READ:  if (cmd_xfer) state_next = ST_WAIT_RESP;
            ST_WAIT_RESP: if (resp_xfer || timeout_hit) state_next = ST_OUT_LO;
            ST_OUT_LO:    if (out_xfer) state_next = ST_OUT_HI;
            ST_OUT_HI: begin
                if (out_xfer) begin
                    if (!last_index) begin
                        state_next = ST_CMD_READ;
                    end else if (clear_pending) begin
                        state_next = ST_CMD_RESET;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_CMD_RESET: if (cmd_xfer) state_next = ST_FINISH;
            ST_FINISH:    state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // All outputs decode from the registered state only, so no have depends on a want.
    always_comb begin
        o_busy      = (state != ST_IDLE);
        o_done      = 1'b0;
        o_cmd_data  = '0;
        o_cmd_have  = 1'b0;
        o_resp_want = 1'b0;
        o_out_data  = '0;
        o_out_have  = 1'b0;
        unique case (state)
            ST_CMD_READ: begin
                o_cmd_have = 1'b1;
                o_cmd_data = make_cmd(index, DBG_CMD_READ);
            end
            ST_WAIT_RESP: o_resp_want = 1'b1;
            ST_OUT_LO: begin
                o_out_have = 1'b1;
                o_out_data = capture[31:0];
            end
            ST_OUT_HI: begin
                o_out_have = 1'b1;
                o_out_data = capture[63:32];
            end
            ST_CMD_RESET: begin
                o_cmd_have = 1'b1;
                o_cmd_data = make_cmd(16'd0, DBG_CMD_RESET);
            end
            ST_FINISH: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk150 or posedge i_reset) begin
        if (i_reset) begin
            index         <= '0;
            clear_pending <= 1'b0;
            capture       <= '0;
        end else begin
            if (state == ST_IDLE && i_start) begin
                index         <= '0;
                clear_pending <= i_clear;
            end else if (state == ST_OUT_HI && out_xfer && !last_index) begin
                index <= index + 16'd1;
            end
            if (resp_xfer) begin
                capture <= i_resp_data;
            end else if (timeout_hit) begin
                capture <= DBG_INVALID_MARKER;
            end
        end
    end

endmodule

// File: tb/tb_dbg_stats_reader.sv
// Self-checking bench for dbg_stats_reader: transaction-level model of the
// expected command and word streams plus directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_dbg_stats_reader;
    import dbg_stats_reader_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;

    typedef struct {
        logic [63:0] data;
        int          ready;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] cmd_data;
    logic        cmd_have;
    logic        cmd_want = 1'b1;
    logic [63:0] resp_data = '0;
    logic        resp_have = 1'b0;
    logic        resp_want;
    logic [31:0] out_data;
    logic        out_have;
    logic        out_want = 1'b1;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int target_done = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int resp_delay = 0;
    int silent_idx = -1;
    bit toggle_mode = 1'b0;
    bit busy_m = 1'b0;
    bit resp_taken = 1'b0;

    logic [31:0] exp_cmd[$];
    logic [31:0] exp_out[$];
    logic [31:0] cmd_log[$];
    logic [31:0] out_log[$];
    resp_t       resp_q[$];

    dbg_stats_reader #(.N_COUNTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk150    (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_clear     (clear),
        .o_busy      (busy),
        .o_done      (done),
        .o_cmd_data  (cmd_data),
        .o_cmd_have  (cmd_have),
        .i_cmd_want  (cmd_want),
        .i_resp_data (resp_data),
        .i_resp_have (resp_have),
        .o_resp_want (resp_want),
        .o_out_data  (out_data),
        .o_out_have  (out_have),
        .i_out_want  (out_want),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] model_value(input int idx);
        if (idx == silent_idx) return DBG_INVALID_MARKER;
        return 64'(idx) * 64'h0000_0001_0000_0001;
    endfunction

    // Transaction model: expected streams are built when an operation is accepted.
    initial begin
        bit busy_next;
        bit prev_cmd_stall;
        bit prev_out_stall;
        logic [31:0] prev_cmd_data;
        logic [31:0] prev_out_data;
        logic [63:0] expv;
        logic [63:0] v;
        prev_cmd_stall = 1'b0;
        prev_out_stall = 1'b0;
        prev_cmd_data  = '0;
        prev_out_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_m = 1'b0;
                exp_cmd.delete();
                exp_out.delete();
                prev_cmd_stall = 1'b0;
                prev_out_stall = 1'b0;
                check_output("reset_flags", 64'({busy, done, cmd_have, resp_want, out_have, err}), 64'd0);
                check_output("reset_cmd_data", 64'(cmd_data), 64'd0);
                check_output("reset_out_data", 64'(out_data), 64'd0);
            end else begin
                busy_next = busy_m;
                check_output("busy", 64'(busy), 64'(busy_m));
                if (silent_idx < 0) check_output("err_clear", 64'(err), 64'd0);
                if (prev_cmd_stall) begin
                    check_output("cmd_hold_have", 64'(cmd_have), 64'd1);
                    check_output("cmd_hold_data", 64'(cmd_data), 64'(prev_cmd_data));
                end
                if (prev_out_stall) begin
                    check_output("out_hold_have", 64'(out_have), 64'd1);
                    check_output("out_hold_data", 64'(out_data), 64'(prev_out_data));
                end
                if (cmd_have && cmd_want) begin
                    cmd_log.push_back(cmd_data);
                    expv = '1;
                    if (exp_cmd.size() > 0) expv = 64'(exp_cmd.pop_front());
                    check_output("cmd_stream", 64'(cmd_data), expv);
                    if (cmd_data[15:0] == DBG_CMD_READ && int'(cmd_data[31:16]) != silent_idx) begin
                        resp_q.push_back('{data: model_value(int'(cmd_data[31:16])), ready: cyc + resp_delay});
                    end
                end
                if (resp_have && resp_want) resp_taken = 1'b1;
                if (out_have && out_want) begin
                    out_log.push_back(out_data);
                    expv = '1;
                    if (exp_out.size() > 0) expv = 64'(exp_out.pop_front());
                    check_output("out_stream", 64'(out_data), expv);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check_output("done_cmds_left", 64'(exp_cmd.size()), 64'd0);
                    check_output("done_words_left", 64'(exp_out.size()), 64'd0);
                    busy_next = 1'b0;
                end
                if (!busy_m && (start || clear)) begin
                    busy_next = 1'b1;
                    start_cyc = cyc;
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            exp_cmd.push_back({16'(i), DBG_CMD_READ});
                            v = model_value(i);
                            exp_out.push_back(v[31:0]);
                            exp_out.push_back(v[63:32]);
                        end
                    end
                    if (clear) exp_cmd.push_back({16'd0, DBG_CMD_RESET});
                end
                busy_m = busy_next;
                prev_cmd_stall = cmd_have && !cmd_want;
                prev_cmd_data  = cmd_data;
                prev_out_stall = out_have && !out_want;
                prev_out_data  = out_data;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rst) begin
            resp_q.delete();
            resp_have  = 1'b0;
            resp_taken = 1'b0;
        end else begin
            if (resp_taken) begin
                resp_have  = 1'b0;
                resp_taken = 1'b0;
            end
            if (!resp_have && resp_q.size() > 0 && cyc >= resp_q[0].ready) begin
                resp_data = resp_q[0].data;
                resp_have = 1'b1;
                void'(resp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_want = toggle_mode ? cyc[0] : 1'b1;
    end

    task automatic apply_stimulus(input logic s, input logic c);
        target_done = done_cnt + 1;
        @(posedge clk);
        #1;
        start = s;
        clear = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target_done) break;
        end
        check_output("done_seen", 64'(done_cnt), 64'(target_done));
    endtask

    task automatic check_sweep_words(input string name);
        logic [31:0] words [6];
        words = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2};
        check_output({name, "_count"}, 64'(out_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            check_output(name, 64'(out_log[i]), 64'(words[i]));
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        out_log.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back sweep: 4 cycles per index, done on the 13th cycle after start.
        clear_logs();
        apply_stimulus(1'b1, 1'b0);
        wait_done(200);
        check_output("t1_latency", 64'(done_cyc - start_cyc), 64'd13);
        check_sweep_words("t1_words");
        check_output("t1_cmd_count", 64'(cmd_log.size()), 64'd3);

        clear_logs();
        toggle_mode = 1'b1;
        resp_delay  = 5;
        apply_stimulus(1'b1, 1'b0);
        wait_done(400);
        check_sweep_words("t2_words");
        toggle_mode = 1'b0;
        resp_delay  = 0;
        repeat (2) @(posedge clk);

        clear_logs();
        apply_stimulus(1'b1, 1'b1);
        wait_done(200);
        check_output("t3_cmd_count", 64'(cmd_log.size()), 64'd4);
        if (cmd_log.size() == 4) begin
            check_output("t3_cmd0", 64'(cmd_log[0]), 64'h0000_0000);
            check_output("t3_cmd1", 64'(cmd_log[1]), 64'h0001_0000);
            check_output("t3_cmd2", 64'(cmd_log[2]), 64'h0002_0000);
            check_output("t3_cmd3", 64'(cmd_log[3]), 64'h0000_0001);
        end

        clear_logs();
        apply_stimulus(1'b0, 1'b1);
        wait_done(50);
        check_output("t3b_cmd_count", 64'(cmd_log.size()), 64'd1);
        if (cmd_log.size() > 0) check_output("t3b_cmd0", 64'(cmd_log[0]), 64'h0000_0001);
        check_output("t3b_words", 64'(out_log.size()), 64'd0);

        clear_logs();
        apply_stimulus(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        wait_done(200);
        repeat (20) @(posedge clk);
        #1;
        check_output("t4_single_done", 64'(done_cnt), 64'(target_done));
        check_output("t4_idle", 64'(busy), 64'd0);
        check_output("t4_cmd_count", 64'(cmd_log.size()), 64'd3);

        // Abort in OUT_HI of index 1, then confirm a fresh sweep restarts at index 0.
        clear_logs();
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_log.size() == 3) break;
        end
        check_output("t5_pre_words", 64'(out_log.size()), 64'd3);
        check_output("t5_hi_word", 64'(out_data), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("t5_busy_reset", 64'(busy), 64'd0);
        check_output("t5_out_reset", 64'({out_have, out_data}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        apply_stimulus(1'b1, 1'b0);
        wait_done(200);
        if (cmd_log.size() > 0) check_output("t5_restart_idx", 64'(cmd_log[0]), 64'h0000_0000);
        check_sweep_words("t5_words");

`ifdef DBG_READER_TIMEOUT_EN
        clear_logs();
        silent_idx = 2;
        apply_stimulus(1'b1, 1'b0);
        wait_done(400);
        check_output("t6_latency", 64'(done_cyc - start_cyc), 64'd28);
        check_output("t6_count", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            check_output("t6_lo", 64'(out_log[4]), 64'hBAADF00D);
            check_output("t6_hi", 64'(out_log[5]), 64'hDEADBEEF);
        end
        repeat (5) @(posedge clk);
        #1;
        check_output("t6_err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("t6_err_reset", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        silent_idx = -1;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
